// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational bfloat16 adder among N_REQ requesters.
// One operation in flight: IDLE accepts, EXEC captures the adder sum, RESP returns it.
module fp_add_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_op,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    input  logic [WIDTH-1:0]         add_p,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    input  logic [N_REQ-1:0]         rsp_ready,
    output logic [15:0]              ops_done
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;

    // Rotating search starting just after the previous winner.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Subtraction is folded into the operand by flipping b's sign bit.
    always_comb begin
        win_a = req_a[int'(win)*WIDTH +: WIDTH];
        win_b = req_b[int'(win)*WIDTH +: WIDTH];
        if (req_op[win]) begin
            win_b[WIDTH-1] = ~win_b[WIDTH-1];
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready[win] = 1'b1;
                    state_next     = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                rsp_valid[grant_idx] = 1'b1;
                if (rsp_ready[grant_idx]) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_idx  <= '0;
            last_grant <= IDX_W'(N_REQ - 1);
            op_a       <= '0;
            op_b       <= '0;
            res        <= '0;
            ops_done   <= '0;
        end else begin
            if (state == IDLE && found) begin
                op_a       <= win_a;
                op_b       <= win_b;
                grant_idx  <= win;
                last_grant <= win;
            end
            if (state == EXEC) begin
                res <= add_p;
            end
            if (state == RESP && rsp_ready[grant_idx]) begin
                ops_done <= ops_done + 16'd1;
            end
        end
    end

    assign add_a    = op_a;
    assign add_b    = op_b;
    assign rsp_data = res;

endmodule
